// File: rtl/instr_pkg.sv
// Shared instruction-format package: IR width, field positions, opcodes and
// encode/legality helpers. Used by the encoder and the execute unit.
package instr_pkg;

  localparam int IR_W         = 32;
  localparam int OPER_W       = 5;
  localparam int REG_W        = 5;
  localparam int IMM_W        = 16;
  localparam int OPER_LSB     = 27;
  localparam int RDST_LSB     = 22;
  localparam int RSRC1_LSB    = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_LSB    = 11;

  typedef enum logic [OPER_W-1:0] {
    OP_MOVSGPR = 5'b00000,
    OP_MOV     = 5'b00001,
    OP_ADD     = 5'b00010,
    OP_SUB     = 5'b00011,
    OP_MUL     = 5'b00100
  } opcode_e;

  // True for the opcodes the execute unit implements.
  function automatic logic is_legal_op(input logic [OPER_W-1:0] op);
    logic legal;
    case (op)
      OP_MOVSGPR, OP_MOV, OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Packs the instruction fields; in register mode the low 11 bits are zero
  // and the immediate is ignored.
  function automatic logic [IR_W-1:0] encode_ir(
    input logic [OPER_W-1:0] oper,
    input logic [REG_W-1:0]  rdst,
    input logic [REG_W-1:0]  rsrc1,
    input logic              imm_mode,
    input logic [REG_W-1:0]  rsrc2,
    input logic [IMM_W-1:0]  imm
  );
    logic [IR_W-1:0] ir;
    ir                          = '0;
    ir[OPER_LSB  +: OPER_W]     = oper;
    ir[RDST_LSB  +: REG_W]      = rdst;
    ir[RSRC1_LSB +: REG_W]      = rsrc1;
    ir[IMM_MODE_BIT]            = imm_mode;
    if (imm_mode) begin
      ir[0 +: IMM_W]            = imm;
    end else begin
      ir[RSRC2_LSB +: REG_W]    = rsrc2;
    end
    return ir;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded instruction words. DEPTH must be a power of 2
// so the pointers wrap naturally. Head word reads as zero when empty.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  // A full FIFO never takes a push, even when it is being popped this cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];

  // Storage write; contents beyond the occupancy are don't-care.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy, cleared asynchronously so buffered words vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field sets into 32-bit IR words and buffers them
// for a valid/ready consumer. Define INSTR_ILLEGAL_CHK_EN to drop illegal
// opcodes (handshake still completes) and raise the sticky err flag.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPER_W-1:0] in_oper,
  input  logic [REG_W-1:0]  in_rdst,
  input  logic [REG_W-1:0]  in_rsrc1,
  input  logic              in_imm_mode,
  input  logic [REG_W-1:0]  in_rsrc2,
  input  logic [IMM_W-1:0]  in_imm,
  output logic [IR_W-1:0]   out_ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       enc_count,
  output logic              err,
  input  logic              err_clr
);

  logic            w_accept;
  logic            w_push;
  logic            w_illegal;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [IR_W-1:0] w_ir;
  logic            r_ready_en;
  logic [15:0]     r_enc_count;
  logic            r_err;

  assign w_ir      = encode_ir(in_oper, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm);
  assign in_ready  = r_ready_en & ~w_full;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign enc_count = r_enc_count;
  assign err       = r_err;

`ifdef INSTR_ILLEGAL_CHK_EN
  logic w_legal;
  assign w_legal   = is_legal_op(in_oper);
  assign w_push    = w_accept & w_legal;
  assign w_illegal = w_accept & ~w_legal;
`else
  assign w_push    = w_accept;
  assign w_illegal = 1'b0;
`endif

  instr_fifo #(
    .WIDTH (IR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (sys_rst),
    .i_push  (w_push),
    .i_data  (w_ir),
    .i_pop   (w_pop),
    .o_data  (out_ir),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Hold off input acceptance until the first clock after reset release.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // Count of words pushed into the buffer, wrapping at 16 bits.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_enc_count <= 16'h0000;
    end else if (w_push) begin
      r_enc_count <= r_enc_count + 16'h0001;
    end else begin
      r_enc_count <= r_enc_count;
    end
  end

  // Sticky illegal-opcode flag; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model compared
// every cycle, directed literal checks, then randomized traffic and a 16-bit
// count wrap. Build with INSTR_ILLEGAL_CHK_EN to exercise the checked variant.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_oper;
  logic [4:0]  in_rdst;
  logic [4:0]  in_rsrc1;
  logic        in_imm_mode;
  logic [4:0]  in_rsrc2;
  logic [15:0] in_imm;
  logic [31:0] out_ir;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] enc_count;
  logic        err;
  logic        err_clr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_oper     (in_oper),
    .in_rdst     (in_rdst),
    .in_rsrc1    (in_rsrc1),
    .in_imm_mode (in_imm_mode),
    .in_rsrc2    (in_rsrc2),
    .in_imm      (in_imm),
    .out_ir      (out_ir),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .enc_count   (enc_count),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Reference encoding from the field layout, by arithmetic.
  function automatic logic [31:0] ir_of(input int op, input int rd, input int rs1,
                                        input int im, input int rs2, input int imm);
    longint v;
    v = longint'(op) * 134217728 + longint'(rd) * 4194304 + longint'(rs1) * 131072
      + longint'(im) * 65536 + ((im != 0) ? longint'(imm) : longint'(rs2) * 2048);
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  logic [15:0] m_cnt = 16'h0000;
  bit          m_err = 1'b0;
  bit          m_rdy = 1'b0;

  always @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      q.delete();
      m_cnt = 16'h0000;
      m_err = 1'b0;
      m_rdy = 1'b0;
    end else begin
      bit acc, pop, legal, do_push, ill;
      acc   = in_valid && m_rdy && (q.size() < DEPTH);
      pop   = (q.size() != 0) && out_ready;
      legal = (in_oper <= 5'd4);
`ifdef INSTR_ILLEGAL_CHK_EN
      do_push = acc && legal;
      ill     = acc && !legal;
`else
      do_push = acc;
      ill     = 1'b0;
      legal   = 1'b1;
`endif
      if (pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(ir_of(int'(in_oper), int'(in_rdst), int'(in_rsrc1),
                          int'(in_imm_mode), int'(in_rsrc2), int'(in_imm)));
        m_cnt = m_cnt + 16'd1;
      end
      if (ill) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_rdy = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("mdl_out_ir",    out_ir, (q.size() != 0) ? q[0] : 32'h0);
      chk("mdl_in_ready",  32'(in_ready), 32'(m_rdy && (q.size() < DEPTH) && !sys_rst));
      chk("mdl_enc_count", 32'(enc_count), 32'(m_cnt));
      chk("mdl_err",       32'(err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_fields(input int op, input int rd, input int rs1,
                            input int im, input int rs2, input int imm);
    in_oper = 5'(op); in_rdst = 5'(rd); in_rsrc1 = 5'(rs1);
    in_imm_mode = 1'(im); in_rsrc2 = 5'(rs2); in_imm = 16'(imm);
  endtask

  task automatic send(input int op, input int rd, input int rs1,
                      input int im, input int rs2, input int imm);
    set_fields(op, rd, rs1, im, rs2, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_w [5];
  logic [31:0] got_w [5];
  int          got;
  int          n;
  bit          acc;

  initial begin
    sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_ir",    out_ir, 32'h0);
    chk("rst_in_ready",  32'(in_ready), 32'h0);
    chk("rst_enc_count", 32'(enc_count), 32'h0);
    chk("rst_err",       32'(err), 32'h0);
    sys_rst = 1'b0;
    chk_en  = 1'b1;
    step();
    chk("rdy_after_rel", 32'(in_ready), 32'h1);
    out_ready = 1'b1;

    // add immediate
    chk("pin_model_add", ir_of(2, 3, 1, 1, 9, 5), 32'h10C30005);
    send(2, 3, 1, 1, 9, 16'h0005);
    @(negedge clk);
    chk("add_out_ir",    out_ir, 32'h10C30005);
    chk("add_out_valid", 32'(out_valid), 32'h1);
    chk("add_enc_count", 32'(enc_count), 32'h1);

    // mul register form, immediate ignored
    send(4, 5, 6, 0, 7, 16'hFFFF);
    @(negedge clk);
    chk("mul_out_ir", out_ir, 32'h214C3800);
    step(); step();

    // fill with consumer stalled, fifth held, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_w[i] = ir_of(i, i + 1, i + 2, i % 2, i + 3, 16'h1111 * (i + 1));
    chk("pin_model_w0", exp_w[0], 32'h00441800);
    for (int i = 0; i < 4; i++) send(i, i + 1, i + 2, i % 2, i + 3, 16'h1111 * (i + 1));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    step();
    set_fields(4, 5, 6, 0, 7, 16'h5555);
    in_valid = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    chk("stall_out_ir",   out_ir, exp_w[0]);
    step();
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin got_w[got] = out_ir; got++; end
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("drain_words", 32'(got), 32'd5);
    for (int i = 0; i < got; i++) chk($sformatf("drain_w%0d", i), got_w[i], exp_w[i]);
    in_valid = 1'b0;
    step(); step();

    // illegal opcode 00111 (7 words accepted so far)
`ifdef INSTR_ILLEGAL_CHK_EN
    send(7, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ill_out_valid", 32'(out_valid), 32'h0);
    chk("ill_err",       32'(err), 32'h1);
    chk("ill_enc_count", 32'(enc_count), 32'd7);
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    @(negedge clk);
    chk("ill_err_clr", 32'(err), 32'h0);
    step();
    set_fields(7, 1, 1, 0, 1, 0);
    in_valid = 1'b1; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("ill_set_wins", 32'(err), 32'h1);
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
`else
    send(7, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ill_out_ir",    out_ir, 32'h38000000);
    chk("ill_err",       32'(err), 32'h0);
    chk("ill_enc_count", 32'(enc_count), 32'd8);
`endif
    step(); step();

    // mid-cycle reset with two words buffered
    out_ready = 1'b0;
    send(1, 2, 3, 1, 0, 16'hABCD);
    send(3, 4, 5, 0, 6, 0);
    @(posedge clk); #3;
    sys_rst = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    chk("mrst_enc_count", 32'(enc_count), 32'h0);
    chk("mrst_out_ir",    out_ir, 32'h0);
    chk("mrst_in_ready",  32'(in_ready), 32'h0);
    @(posedge clk); #3;
    sys_rst = 1'b0;
    step();
    chk("mrst_rdy_rel", 32'(in_ready), 32'h1);
    out_ready = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_fields($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 65535));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    step(); step(); step(); step(); step();

    // 65536 pushes from a fresh reset wrap enc_count back to zero
    sys_rst = 1'b1; step(); sys_rst = 1'b0; step();
    set_fields(1, 2, 3, 0, 4, 0);
    in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 70000 && n < 65536; c++) begin
      @(negedge clk);
      if (n == 65535) chk("wrap_ffff", 32'(enc_count), 32'h0000FFFF);
      acc = in_ready;
      step();
      if (acc) n++;
      if (n == 65536) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("wrap_pushes", 32'(n), 32'd65536);
    @(negedge clk);
    chk("wrap_zero", 32'(enc_count), 32'h0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
